// File: rtl/ofdm_frame_pkg.sv
// ofdm_frame_pkg: constants and state encoding shared by the OFDM frame
// counter (transmit) and frame_tracker (receive).
//   COUNT_SIZE_DEF  : position counter width; a frame is 2^COUNT_SIZE samples
//   ACTIVE_LEN_DEF  : leading samples of each frame with the active flag high
//   LOCK_FRAMES_DEF : clean frames needed in VERIFY before LOCKED
//   LOSS_LIMIT_DEF  : consecutive bad frames in LOCKED before SEARCH
package ofdm_frame_pkg;

  localparam int COUNT_SIZE_DEF  = 12;
  localparam int ACTIVE_LEN_DEF  = 1024;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int LOSS_LIMIT_DEF  = 3;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  // Bits needed to hold a count of 0..limit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: wrapping position counter for the receive frame tracker.
//   clock, reset   : rising-edge clock, async active-high reset
//   load_i         : accepted sample gets position 0 (realignment)
//   adv_i          : accepted sample gets position pos+1 (modular wrap)
//   pos_o          : position of the last accepted sample (registered)
//   nxt_pos_o      : position the current sample would take if accepted
//   nxt_last_o     : nxt_pos_o is the last position of the frame
//   nxt_active_o   : nxt_pos_o lies in the active region (< ACTIVE_LEN)
module frame_pos_counter #(
  parameter int COUNT_SIZE = 12,
  parameter int ACTIVE_LEN = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  adv_i,
  output logic [COUNT_SIZE-1:0] pos_o,
  output logic [COUNT_SIZE-1:0] nxt_pos_o,
  output logic                  nxt_last_o,
  output logic                  nxt_active_o
);

  // One extra bit so ACTIVE_LEN == 2^COUNT_SIZE still compares correctly.
  localparam logic [COUNT_SIZE:0] ACT_LIM = (COUNT_SIZE+1)'(ACTIVE_LEN);

  logic [COUNT_SIZE-1:0] pos_q, pos_d;

  assign nxt_pos_o    = load_i ? '0 : pos_q + COUNT_SIZE'(1);
  assign nxt_last_o   = &nxt_pos_o;
  assign nxt_active_o = ({1'b0, nxt_pos_o} < ACT_LIM);
  assign pos_d        = (load_i || adv_i) ? nxt_pos_o : pos_q;
  assign pos_o        = pos_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pos_q <= '0;
    else       pos_q <= pos_d;
  end

endmodule

// File: rtl/frame_tracker.sv
// frame_tracker: recovers OFDM frame alignment from the per-sample active
// flag and reports the in-frame position of every accepted sample.
//   clock, reset   : rising-edge clock, async active-high reset
//   enable         : block enable; sample accepted on enable && ready_in
//   ready_in       : sample-valid strobe
//   control_signal : received active-region flag of the current sample
//   sample_index   : position of the last accepted sample
//   frame_start    : pulse, last accepted sample had position 0 (aligned)
//   active_out     : locked and last accepted sample in the active region
//   locked         : lock state machine is in LOCKED
//   frame_error    : pulse, a frame containing a flag mismatch ended while LOCKED
//   ready_out      : ready_in delayed one cycle
module frame_tracker
  import ofdm_frame_pkg::*;
#(
  parameter int COUNT_SIZE  = COUNT_SIZE_DEF,
  parameter int ACTIVE_LEN  = ACTIVE_LEN_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int LOSS_LIMIT  = LOSS_LIMIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ready_in,
  input  logic                  control_signal,
  output logic [COUNT_SIZE-1:0] sample_index,
  output logic                  frame_start,
  output logic                  active_out,
  output logic                  locked,
  output logic                  frame_error,
  output logic                  ready_out
);

  localparam int GW = cnt_w(LOCK_FRAMES);
  localparam int MW = cnt_w(LOSS_LIMIT);

  lock_state_e           state_q, state_d;
  logic [GW-1:0]         good_q, good_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic                  bad_q, bad_d;
  logic                  prev_flag_q, prev_flag_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_error_q, frame_error_d;
  logic                  active_q, active_d;
  logic                  locked_q;
  logic                  ready_q;

  logic                  accept, edge_det, load, mismatch;
  logic [COUNT_SIZE-1:0] pos, nxt_pos;
  logic                  nxt_last, nxt_active;

  assign accept   = enable && ready_in;
  assign edge_det = control_signal && !prev_flag_q;
  // Realignment happens only while searching; once in VERIFY/LOCKED the
  // counter free-runs and flag errors never move the frame boundary.
  assign load     = accept && (state_q == ST_SEARCH) && edge_det;
  assign mismatch = (control_signal != nxt_active);

  frame_pos_counter #(
    .COUNT_SIZE (COUNT_SIZE),
    .ACTIVE_LEN (ACTIVE_LEN)
  ) u_pos (
    .clock        (clock),
    .reset        (reset),
    .load_i       (load),
    .adv_i        (accept),
    .pos_o        (pos),
    .nxt_pos_o    (nxt_pos),
    .nxt_last_o   (nxt_last),
    .nxt_active_o (nxt_active)
  );

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    miss_d        = miss_q;
    bad_d         = bad_q;
    prev_flag_d   = prev_flag_q;
    frame_start_d = 1'b0;
    frame_error_d = 1'b0;
    active_d      = active_q;
    if (accept) begin
      prev_flag_d = control_signal;
      case (state_q)
        ST_SEARCH: begin
          if (edge_det) begin
            state_d = ST_VERIFY;
            good_d  = '0;
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_d = ST_SEARCH;
          end else if (nxt_last) begin
            if (good_q == GW'(LOCK_FRAMES - 1)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (nxt_last) begin
            bad_d = 1'b0;
            // The last sample of the frame counts toward its own verdict.
            if (bad_q || mismatch) begin
              frame_error_d = 1'b1;
              if (miss_q == MW'(LOSS_LIMIT - 1)) begin
                state_d = ST_SEARCH;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + MW'(1);
              end
            end else begin
              miss_d = '0;
            end
          end else if (mismatch) begin
            bad_d = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
      if (state_d != ST_LOCKED) bad_d = 1'b0;
      frame_start_d = load || ((state_q != ST_SEARCH) && (nxt_pos == '0));
      active_d      = (state_d == ST_LOCKED) && nxt_active;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      miss_q        <= '0;
      bad_q         <= 1'b0;
      prev_flag_q   <= 1'b1;  // a stream starting mid-active-region is no edge
      frame_start_q <= 1'b0;
      frame_error_q <= 1'b0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      bad_q         <= bad_d;
      prev_flag_q   <= prev_flag_d;
      frame_start_q <= frame_start_d;
      frame_error_q <= frame_error_d;
      active_q      <= active_d;
      locked_q      <= (state_d == ST_LOCKED);
      ready_q       <= ready_in;
    end
  end

  assign sample_index = pos;
  assign frame_start  = frame_start_q;
  assign frame_error  = frame_error_q;
  assign active_out   = active_q;
  assign locked       = locked_q;
  assign ready_out    = ready_q;

endmodule

// File: tb/tb_frame_tracker.sv
// Bench for frame_tracker: a behavioural reference model pushes the expected
// output word for every cycle into a queue; each scenario task pops and
// compares it, and adds scenario-level checks derived from the stream timing.
module tb_frame_tracker;

  localparam int CS = 12;
  localparam int FL = 4096;
  localparam int AL = 1024;

  typedef struct packed {
    logic [CS-1:0] idx;
    logic          fs;
    logic          act;
    logic          lk;
    logic          fe;
    logic          ro;
  } out_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          ready_in = 1'b0;
  logic          control_signal = 1'b0;
  logic [CS-1:0] sample_index;
  logic          frame_start, active_out, locked, frame_error, ready_out;
  out_t          obs;

  assign obs = {sample_index, frame_start, active_out, locked, frame_error, ready_out};

  int   checks = 0;
  int   failures = 0;
  out_t sb[$];
  out_t m_out;
  int   m_state, m_pos, m_good, m_miss;
  bit   m_prev, m_bad;
  int   tx_pos;

  always #5 clock = ~clock;

  frame_tracker dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .ready_in       (ready_in),
    .control_signal (control_signal),
    .sample_index   (sample_index),
    .frame_start    (frame_start),
    .active_out     (active_out),
    .locked         (locked),
    .frame_error    (frame_error),
    .ready_out      (ready_out)
  );

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_good = 0; m_miss = 0;
    m_prev = 1'b1; m_bad = 1'b0; m_out = '0;
    sb.delete();
  endtask

  // Reference behaviour: 0=SEARCH 1=VERIFY 2=LOCKED.
  task automatic model_step(input bit en, input bit rdy, input bit flag);
    int p;
    bit mm;
    m_out.ro = rdy;
    m_out.fs = 1'b0;
    m_out.fe = 1'b0;
    if (en && rdy) begin
      p = (m_pos + 1) % FL;
      mm = (flag != (p < AL));
      case (m_state)
        0: if (flag && !m_prev) begin
             p = 0; m_state = 1; m_good = 0; m_out.fs = 1'b1;
           end
        1: begin
             if (p == 0) m_out.fs = 1'b1;
             if (mm) m_state = 0;
             else if (p == FL - 1) begin
               m_good++;
               if (m_good == 2) begin m_state = 2; m_miss = 0; end
             end
           end
        default: begin
             if (p == 0) m_out.fs = 1'b1;
             if (p == FL - 1) begin
               if (m_bad || mm) begin
                 m_out.fe = 1'b1;
                 m_miss++;
                 if (m_miss == 3) m_state = 0;
               end else m_miss = 0;
               m_bad = 1'b0;
             end else if (mm) m_bad = 1'b1;
           end
      endcase
      m_pos = p;
      m_prev = flag;
      m_out.idx = CS'(p);
      m_out.lk = (m_state == 2);
      m_out.act = m_out.lk && (p < AL);
    end
    sb.push_back(m_out);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit en, input bit rdy, input bit flag);
    enable = en; ready_in = rdy; control_signal = flag;
    model_step(en, rdy, flag);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tx_cycle(input int corrupt_at);
    bit f;
    f = (tx_pos < AL) ^ (tx_pos == corrupt_at);
    cycle(1'b1, 1'b1, f);
    tx_pos = (tx_pos + 1) % FL;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ready_in = 1'b0; control_signal = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    out_t want;
    reset = 1'b1; enable = 1'b1; ready_in = 1'b1; control_signal = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs, out_t'('0));
    end
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 1'b0);
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", obs, want);
    end
    checks++;
    if (obs.ro !== 1'b1 || obs.idx !== '0) begin
      failures++;
      $display("FAIL ready_no_enable got ro=%b idx=%0d want ro=1 idx=0", obs.ro, obs.idx);
    end
  endtask

  task automatic test_flag_high_start();
    out_t want;
    int sent, early, at0;
    do_reset();
    tx_pos = 100; early = 0; at0 = 0;
    for (int n = 0; n < 3997; n++) begin
      sent = tx_pos;
      tx_cycle(-1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL high_start_sb n=%0d got=%h want=%h", n, obs, want);
      end
      if (obs.fs && sent != 0) early++;
      if (sent == 0) at0 = obs.fs;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL high_start_early_fs got=%0d want=0", early);
    end
    checks++;
    if (at0 != 1) begin
      failures++;
      $display("FAIL high_start_edge_fs got=%0d want=1", at0);
    end
  endtask

  task automatic test_clean_acquire();
    out_t want;
    int first_fs, first_lock, act_cnt, fs_cnt;
    do_reset();
    tx_pos = 2000; first_fs = -1; first_lock = -1; act_cnt = 0; fs_cnt = 0;
    for (int n = 0; n < 2096 + 3 * FL; n++) begin
      tx_cycle(-1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL acquire_sb n=%0d got=%h want=%h", n, obs, want);
      end
      if (obs.fs && first_fs < 0) first_fs = n;
      if (obs.lk && first_lock < 0) first_lock = n;
      if (n >= 2096 + 2 * FL) begin
        act_cnt += int'(obs.act);
        fs_cnt += int'(obs.fs);
      end
    end
    checks++;
    if (first_fs != 2096) begin
      failures++;
      $display("FAIL acquire_first_fs got=%0d want=2096", first_fs);
    end
    checks++;
    if (first_lock != 2096 + 2 * FL - 1) begin
      failures++;
      $display("FAIL acquire_lock_time got=%0d want=%0d", first_lock, 2096 + 2 * FL - 1);
    end
    checks++;
    if (act_cnt != AL || fs_cnt != 1) begin
      failures++;
      $display("FAIL acquire_active_count got act=%0d fs=%0d want act=%0d fs=1", act_cnt, fs_cnt, AL);
    end
  endtask

  task automatic test_single_error();
    out_t want;
    int sent, fe_cnt, fe_n, unlk, misalign;
    fe_cnt = 0; fe_n = -1; unlk = 0; misalign = 0;
    for (int n = 0; n < 2 * FL; n++) begin
      sent = tx_pos;
      tx_cycle((n < FL) ? 500 : -1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL single_err_sb n=%0d got=%h want=%h", n, obs, want);
      end
      if (obs.idx !== CS'(sent)) misalign++;
      if (obs.fe) begin fe_cnt++; fe_n = n; end
      if (!obs.lk) unlk++;
    end
    checks++;
    if (fe_cnt != 1 || fe_n != FL - 1) begin
      failures++;
      $display("FAIL single_err_pulse got cnt=%0d at=%0d want cnt=1 at=%0d", fe_cnt, fe_n, FL - 1);
    end
    checks++;
    if (unlk != 0 || misalign != 0) begin
      failures++;
      $display("FAIL single_err_lock got unlocked=%0d misaligned=%0d want 0 0", unlk, misalign);
    end
  endtask

  task automatic test_loss_relock();
    out_t want;
    int fe_cnt, unlock_n, relock_n;
    fe_cnt = 0; unlock_n = -1; relock_n = -1;
    for (int n = 0; n < 5 * FL; n++) begin
      tx_cycle((n < 3 * FL) ? 500 : -1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL loss_sb n=%0d got=%h want=%h", n, obs, want);
      end
      if (obs.fe) fe_cnt++;
      if (!obs.lk && unlock_n < 0) unlock_n = n;
      if (obs.lk && unlock_n >= 0 && relock_n < 0) relock_n = n;
    end
    checks++;
    if (fe_cnt != 3) begin
      failures++;
      $display("FAIL loss_fe_count got=%0d want=3", fe_cnt);
    end
    checks++;
    if (unlock_n != 3 * FL - 1) begin
      failures++;
      $display("FAIL loss_unlock_time got=%0d want=%0d", unlock_n, 3 * FL - 1);
    end
    checks++;
    if (relock_n != 5 * FL - 1) begin
      failures++;
      $display("FAIL relock_time got=%0d want=%0d", relock_n, 5 * FL - 1);
    end
  endtask

  task automatic test_async_reset();
    out_t want;
    int sent, bad_fs, fs_seen;
    for (int n = 0; n < 3001; n++) begin
      tx_cycle(-1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL pre_reset_sb n=%0d got=%h want=%h", n, obs, want);
      end
    end
    checks++;
    if (obs.lk !== 1'b1 || obs.idx !== CS'(3000)) begin
      failures++;
      $display("FAIL pre_reset_pos got lk=%b idx=%0d want lk=1 idx=3000", obs.lk, obs.idx);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", obs);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bad_fs = 0; fs_seen = 0;
    for (int n = 0; n < 1099; n++) begin
      sent = tx_pos;
      tx_cycle(-1);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL reacquire_sb n=%0d got=%h want=%h", n, obs, want);
      end
      if (obs.fs && sent != 0) bad_fs++;
      if (obs.fs && sent == 0) fs_seen++;
    end
    checks++;
    if (bad_fs != 0 || fs_seen != 1) begin
      failures++;
      $display("FAIL reacquire_fs got early=%0d at0=%0d want 0 1", bad_fs, fs_seen);
    end
  endtask

  task automatic test_gaps();
    out_t want;
    bit en, rdy, f, acc, aligned;
    int last, misalign;
    do_reset();
    tx_pos = 3900; aligned = 1'b0; last = 0; misalign = 0;
    for (int c = 0; c < 3000; c++) begin
      en = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      acc = en && rdy;
      if (acc) begin
        last = tx_pos;
        f = (tx_pos < AL);
        tx_pos = (tx_pos + 1) % FL;
      end else begin
        f = 1'($urandom_range(0, 1));
      end
      cycle(en, rdy, f);
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL gaps_sb c=%0d got=%h want=%h", c, obs, want);
      end
      if (obs.fs) aligned = 1'b1;
      if (aligned && obs.idx !== CS'(last)) misalign++;
    end
    checks++;
    if (!aligned || misalign != 0) begin
      failures++;
      $display("FAIL gaps_alignment got aligned=%b misaligned=%0d want 1 0", aligned, misalign);
    end
  endtask

  initial begin
    test_reset();
    test_flag_high_start();
    test_clean_acquire();
    test_single_error();
    test_loss_relock();
    test_async_reset();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
